// File: rtl/message_stream_pkg.sv
// Shared definitions for the message-stream format: header field decoding and arbiter states.
package message_stream_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Words are zero-extended to this width before decoding, so WIDTH may not exceed it.
   localparam int MSG_MAX_W = 64;
   typedef logic [MSG_MAX_W-1:0] msg_word_t;

   function automatic logic msg_is_header(input msg_word_t w, input int width);
      return w[width-1];
   endfunction

   function automatic msg_word_t msg_length(input msg_word_t w, input int width, input int len_w);
      msg_word_t mask;
      mask = (msg_word_t'(1) << len_w) - msg_word_t'(1);
      return (w >> (width - 1 - len_w)) & mask;
   endfunction

endpackage

// File: rtl/message_stream_arbiter_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty and a combinational head word.
module message_fifo #(
   parameter int WIDTH     = 32,
   parameter int LOG_DEPTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             dropped
);

   logic [WIDTH-1:0]   mem [2**LOG_DEPTH];
   logic [LOG_DEPTH:0] wr_ptr;
   logic [LOG_DEPTH:0] rd_ptr;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                    (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dropped = push && !do_push;
   assign rd_data = mem[rd_ptr[LOG_DEPTH-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (LOG_DEPTH+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (LOG_DEPTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[LOG_DEPTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/message_stream_arbiter.sv
// Merges N buffered message streams onto one output, whole packets at a time, round-robin.
module message_stream_arbiter
   import message_stream_pkg::*;
#(
   parameter int N_STREAMS             = 4,
   parameter int LOG_N_STREAMS         = 2,
   parameter int WIDTH                 = 32,
   parameter int LOG_DEPTH             = 6,
   parameter int LOG_MAX_PACKET_LENGTH = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH*N_STREAMS-1:0]    in_data,
   input  logic [N_STREAMS-1:0]          in_nd,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_nd,
   input  logic                          out_ready,
   output logic [LOG_N_STREAMS-1:0]      out_stream,
   input  logic                          err_clear,
   output logic [N_STREAMS-1:0]          err_overflow,
   output logic [N_STREAMS-1:0]          err_orphan,
   output logic                          error
);

   localparam int LML = LOG_MAX_PACKET_LENGTH;

   logic [WIDTH-1:0]         head [N_STREAMS];
   logic [N_STREAMS-1:0]     empty;
   logic [N_STREAMS-1:0]     pop;
   logic [N_STREAMS-1:0]     ovf;
   logic [N_STREAMS-1:0]     orphan;

   arb_state_t               state, state_nxt;
   logic [LOG_N_STREAMS-1:0] last_grant;
   logic [LOG_N_STREAMS-1:0] grant;
   logic [LML-1:0]           remaining;

   logic [LOG_N_STREAMS-1:0] rr_sel;
   logic                     rr_found;
   logic [LOG_N_STREAMS-1:0] src;
   logic                     src_valid;
   logic [WIDTH-1:0]         src_word;
   logic                     src_hdr;
   logic [LML-1:0]           src_len;
   logic                     can_pop;
   logic                     take;
   logic                     load;

   for (genvar g = 0; g < N_STREAMS; g++) begin : g_fifo
      message_fifo #(
         .WIDTH     (WIDTH),
         .LOG_DEPTH (LOG_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (in_nd[g]),
         .wr_data (in_data[WIDTH*(g+1)-1 -: WIDTH]),
         .pop     (pop[g]),
         .rd_data (head[g]),
         .empty   (empty[g]),
         .dropped (ovf[g])
      );
   end

   // Round-robin search starts just after the last stream granted.
   always_comb begin
      int idx;
      idx      = 0;
      rr_sel   = '0;
      rr_found = 1'b0;
      for (int i = 1; i <= N_STREAMS; i++) begin
         idx = (int'(last_grant) + i) % N_STREAMS;
         if (!rr_found && !empty[idx]) begin
            rr_found = 1'b1;
            rr_sel   = LOG_N_STREAMS'(idx);
         end
      end
   end

   assign src       = (state == LOCKED) ? grant : rr_sel;
   assign src_valid = (state == LOCKED) ? !empty[grant] : rr_found;
   assign src_word  = head[src];
   assign src_hdr   = msg_is_header(MSG_MAX_W'(src_word), WIDTH);
   assign src_len   = LML'(msg_length(MSG_MAX_W'(src_word), WIDTH, LML));
   // The output register is the only skid slot, so pop only when it is free or draining.
   assign can_pop   = !out_nd || out_ready;
   assign take      = src_valid && can_pop;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take && src_hdr && (src_len != '0)) state_nxt = LOCKED;
         LOCKED:  if (take && (remaining == LML'(1)))     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop    = '0;
      orphan = '0;
      load   = 1'b0;
      if (take) begin
         pop[src] = 1'b1;
         if ((state == LOCKED) || src_hdr) load = 1'b1;
         else                              orphan[src] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data     <= '0;
         out_nd       <= 1'b0;
         out_stream   <= '0;
         last_grant   <= LOG_N_STREAMS'(N_STREAMS - 1);
         grant        <= '0;
         remaining    <= '0;
         err_overflow <= '0;
         err_orphan   <= '0;
      end else begin
         if (load) begin
            out_data   <= src_word;
            out_stream <= src;
            out_nd     <= 1'b1;
         end else if (out_ready) begin
            out_nd     <= 1'b0;
         end
         if ((state == IDLE) && load) begin
            remaining  <= src_len;
            grant      <= src;
            last_grant <= src;
         end else if ((state == LOCKED) && take) begin
            remaining  <= remaining - LML'(1);
         end
         // New errors override a simultaneous clear.
         err_overflow <= (err_clear ? '0 : err_overflow) | ovf;
         err_orphan   <= (err_clear ? '0 : err_orphan) | orphan;
      end
   end

   assign error = |{err_overflow, err_orphan};

endmodule
